// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the unified memory.
//   slave  : arbiter view (pipeline requests and memory ack in, ready/data and mem_* out)
//   master : environment view (pipeline stages plus memory)
interface unified_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = DW / 8;

  // fetch stage
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          iflush;
  logic          iready;
  logic [DW-1:0] irdata;
  // memory stage
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [BW-1:0] dbe;
  logic          dready;
  logic [DW-1:0] drdata;
  // unified memory
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ireq, iaddr, iflush, dreq, dwe, daddr, dwdata, dbe, mem_ack, mem_rdata,
    output iready, irdata, dready, drdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output ireq, iaddr, iflush, dreq, dwe, daddr, dwdata, dbe, mem_ack, mem_rdata,
    input  iready, irdata, dready, drdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and
// data load/store. Request/grant FSM with registered memory-side outputs, read-data
// capture and one-cycle iready/dready pulses.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : unified_mem_arbiter_if.slave (fetch, data and memory handshakes)
// Optional: define UNIFIED_MEM_ARB_RR_EN for round-robin on contention
// (default build uses fixed data priority).
module unified_mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

  state_t        state, state_nxt;
  logic          mem_req_q, mem_req_nxt;
  logic          mem_we_q, mem_we_nxt;
  logic [AW-1:0] mem_addr_q, mem_addr_nxt;
  logic [DW-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [BW-1:0] mem_be_q, mem_be_nxt;
  logic          iready_q, iready_nxt;
  logic          dready_q, dready_nxt;
  logic [DW-1:0] irdata_q, irdata_nxt;
  logic [DW-1:0] drdata_q, drdata_nxt;
  logic          kill_q, kill_nxt;
  logic          grant_d;

`ifdef UNIFIED_MEM_ARB_RR_EN
  // 1 = data port received the most recent grant
  logic last_d_q, last_d_nxt;
  assign grant_d = bus.dreq & (~bus.ireq | ~last_d_q);
`else
  // data always wins: the older instruction sits in the memory stage
  assign grant_d = bus.dreq;
`endif

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      kill_q      <= 1'b0;
`ifdef UNIFIED_MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      mem_be_q    <= mem_be_nxt;
      iready_q    <= iready_nxt;
      dready_q    <= dready_nxt;
      irdata_q    <= irdata_nxt;
      drdata_q    <= drdata_nxt;
      kill_q      <= kill_nxt;
`ifdef UNIFIED_MEM_ARB_RR_EN
      last_d_q    <= last_d_nxt;
`endif
    end
  end

  // next-state and next-output decode; ready pulses are high only in the RESP states
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req_q;
    mem_we_nxt    = mem_we_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    mem_be_nxt    = mem_be_q;
    iready_nxt    = 1'b0;
    dready_nxt    = 1'b0;
    irdata_nxt    = irdata_q;
    drdata_nxt    = drdata_q;
    kill_nxt      = kill_q;
`ifdef UNIFIED_MEM_ARB_RR_EN
    last_d_nxt    = last_d_q;
`endif

    unique case (state)
      IDLE: begin
        if (grant_d) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = bus.dwe;
          mem_addr_nxt  = bus.daddr;
          mem_wdata_nxt = bus.dwdata;
          mem_be_nxt    = bus.dbe;
          state_nxt     = DBUSY;
`ifdef UNIFIED_MEM_ARB_RR_EN
          last_d_nxt    = 1'b1;
`endif
        end else if (bus.ireq) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = bus.iaddr;
          mem_be_nxt    = '1;
          state_nxt     = IBUSY;
`ifdef UNIFIED_MEM_ARB_RR_EN
          last_d_nxt    = 1'b0;
`endif
        end
      end
      IBUSY: begin
        // a flush in any busy cycle, ack cycle included, suppresses the iready pulse
        kill_nxt = kill_q | bus.iflush;
        if (bus.mem_ack) begin
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          irdata_nxt  = bus.mem_rdata;
          iready_nxt  = ~(kill_q | bus.iflush);
          state_nxt   = IRESP;
        end
      end
      DBUSY: begin
        if (bus.mem_ack) begin
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (!mem_we_q) drdata_nxt = bus.mem_rdata;
          dready_nxt  = 1'b1;
          state_nxt   = DRESP;
        end
      end
      IRESP: begin
        kill_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      DRESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.iready    = iready_q;
  assign bus.dready    = dready_q;
  assign bus.irdata    = irdata_q;
  assign bus.drdata    = drdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed requests push expected memory
// transactions and ready responses; independent monitors pop and compare.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  unified_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } rsp_exp_t;

  mem_exp_t    exp_mem[$];
  rsp_exp_t    exp_rsp[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_wait = 0;
  int          icount = 0;
  int          last_req_len = 0;
  logic [31:0] irdata_m = '0;
  logic [31:0] drdata_m = '0;

  // memory contents seen by reads
  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: rd = 32'h0050_0093;
      32'h0000_0200: rd = 32'h0000_1234;
      32'h0000_0040: rd = 32'h1111_2222;
      default:       rd = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    mem_exp_t m;
    rsp_exp_t r;
    m.addr = a; m.we = 1'b0; m.wdata = '0; m.be = 4'hF;
    exp_mem.push_back(m);
    irdata_m = rd(a);
    r.is_i = 1'b1; r.data = irdata_m;
    exp_rsp.push_back(r);
  endtask

  task automatic push_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] be);
    mem_exp_t m;
    rsp_exp_t r;
    m.addr = a; m.we = we; m.wdata = wd; m.be = be;
    exp_mem.push_back(m);
    if (!we) drdata_m = rd(a);
    r.is_i = 1'b0; r.data = drdata_m;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_ready(input bit is_i, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = is_i ? bus.iready : bus.dready;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no ready within 64 cycles", is_i ? "iready" : "dready");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"},   32'(bus.mem_req),   32'h0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
    chk({tag, "_mem_be"},    32'(bus.mem_be),    32'h0);
    chk({tag, "_iready"},    32'(bus.iready),    32'h0);
    chk({tag, "_dready"},    32'(bus.dready),    32'h0);
    chk({tag, "_irdata"},    bus.irdata,         32'h0);
    chk({tag, "_drdata"},    bus.drdata,         32'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    irdata_m = '0;
    drdata_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // memory model: acks after ack_wait wait cycles, read data from rd()
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) wcnt = 0;
      else if (wcnt == ack_wait) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rd(bus.mem_addr);
        wcnt = 0;
      end else wcnt++;
    end
  end

  // memory-side monitor: new transaction popped on mem_req rise, then held stable
  initial begin
    logic     prev_req;
    int       len;
    mem_exp_t m;
    mem_exp_t hold;
    prev_req = 1'b0;
    len = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        len = 0;
      end else begin
        if (bus.mem_req && !prev_req) begin
          len = 1;
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: request to 0x%08h with none expected", bus.mem_addr);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_addr", bus.mem_addr, m.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(m.we));
            chk("mem_be", 32'(bus.mem_be), 32'(m.be));
            if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
          end
          hold.addr = bus.mem_addr; hold.we = bus.mem_we;
          hold.wdata = bus.mem_wdata; hold.be = bus.mem_be;
        end else if (bus.mem_req && prev_req) begin
          len++;
          chk("mem_addr_hold", bus.mem_addr, hold.addr);
          chk("mem_wdata_hold", bus.mem_wdata, hold.wdata);
          chk("mem_we_be_hold", 32'({bus.mem_we, bus.mem_be}), 32'({hold.we, hold.be}));
        end else if (!bus.mem_req && prev_req) begin
          last_req_len = len;
        end
        prev_req = bus.mem_req;
      end
    end
  end

  // response monitor: every ready pulse must match the head of the scoreboard
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (!reset && (bus.iready || bus.dready)) begin
        if (bus.iready) icount++;
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready_unexpected: iready=%0b dready=%0b with none expected",
                   bus.iready, bus.dready);
        end else begin
          r = exp_rsp.pop_front();
          chk("ready_port", 32'({bus.iready, bus.dready}), r.is_i ? 32'h2 : 32'h1);
          if (r.is_i) chk("irdata", bus.irdata, r.data);
          else        chk("drdata", bus.drdata, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int guard;
    int ic0;
    bus.ireq = 1'b0; bus.iaddr = '0; bus.iflush = 1'b0;
    bus.dreq = 1'b0; bus.dwe = 1'b0; bus.daddr = '0; bus.dwdata = '0; bus.dbe = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // contention: data (load 0x40) wins, fetch 0x8 follows
    ack_wait = 1;
    push_data(32'h40, 1'b0, 32'h0, 4'hF);
    push_fetch(32'h8);
    bus.daddr = 32'h40; bus.dwe = 1'b0; bus.dbe = 4'hF;
    bus.iaddr = 32'h8;
    bus.dreq = 1'b1; bus.ireq = 1'b1;
    wait_ready(1'b0, lat);
    bus.dreq = 1'b0;
    wait_ready(1'b1, lat);
    bus.ireq = 1'b0;

    // fetch 0x100, ack one cycle after mem_req rises
    ack_wait = 1;
    push_fetch(32'h100);
    bus.iaddr = 32'h100; bus.ireq = 1'b1;
    wait_ready(1'b1, lat);
    bus.ireq = 1'b0;
    chk("fetch_latency", 32'(lat), 32'd4);
    chk("fetch_req_len", 32'(last_req_len), 32'd2);
    chk("fetch_irdata_hold", bus.irdata, 32'h0050_0093);

    // store with three wait cycles, drdata keeps the earlier load value
    ack_wait = 3;
    push_data(32'h2004, 1'b1, 32'hDEAD_BEEF, 4'h3);
    bus.daddr = 32'h2004; bus.dwe = 1'b1; bus.dwdata = 32'hDEAD_BEEF; bus.dbe = 4'h3;
    bus.dreq = 1'b1;
    wait_ready(1'b0, lat);
    bus.dreq = 1'b0;
    chk("store_req_len", 32'(last_req_len), 32'd4);
    chk("store_drdata", bus.drdata, 32'h1111_2222);

    // flush in a wait cycle, then flush in the ack cycle
    for (int f = 0; f < 2; f++) begin
      mem_exp_t m;
      ack_wait = (f == 0) ? 2 : 0;
      m.addr = (f == 0) ? 32'h200 : 32'h204; m.we = 1'b0; m.wdata = '0; m.be = 4'hF;
      exp_mem.push_back(m);
      irdata_m = rd(m.addr);
      ic0 = icount;
      bus.iaddr = m.addr; bus.ireq = 1'b1;
      @(posedge clk); #1;
      bus.iflush = 1'b1; bus.ireq = 1'b0;
      @(posedge clk); #1;
      bus.iflush = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk(f == 0 ? "flush_wait_no_iready" : "flush_ack_no_iready", 32'(icount - ic0), 32'd0);
      chk(f == 0 ? "flush_wait_irdata" : "flush_ack_irdata", bus.irdata, irdata_m);
    end

    // normal fetch after the flushes
    ack_wait = 0;
    push_fetch(32'h108);
    bus.iaddr = 32'h108; bus.ireq = 1'b1;
    wait_ready(1'b1, lat);
    bus.ireq = 1'b0;
    chk("postflush_latency", 32'(lat), 32'd3);

    // reset in the middle of a long store
    ack_wait = 10;
    begin
      mem_exp_t m;
      m.addr = 32'h2008; m.we = 1'b1; m.wdata = 32'hCAFE_F00D; m.be = 4'hF;
      exp_mem.push_back(m);
    end
    bus.daddr = 32'h2008; bus.dwe = 1'b1; bus.dwdata = 32'hCAFE_F00D; bus.dbe = 4'hF;
    bus.dreq = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    irdata_m = '0; drdata_m = '0;
    #1;
    check_reset_vals("midrst");
    bus.dreq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    ack_wait = 1;
    push_fetch(32'h10C);
    bus.iaddr = 32'h10C; bus.ireq = 1'b1;
    wait_ready(1'b1, lat);
    bus.ireq = 1'b0;

    // both requesters held high, immediate ack
    pulse_reset();
    @(posedge clk); #1;
    ack_wait = 0;
`ifdef UNIFIED_MEM_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      push_data(32'h300, 1'b0, 32'h0, 4'hF);
      push_fetch(32'h400);
    end
`else
    for (int k = 0; k < 4; k++) push_data(32'h300, 1'b0, 32'h0, 4'hF);
    push_fetch(32'h400);
`endif
    bus.daddr = 32'h300; bus.dwe = 1'b0; bus.dbe = 4'hF;
    bus.iaddr = 32'h400;
    bus.dreq = 1'b1; bus.ireq = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (bus.iready || bus.dready) n++;
    end
    chk("rr_ready_count", 32'(n), 32'd4);
    @(posedge clk); #1;
    bus.dreq = 1'b0;
`ifdef UNIFIED_MEM_ARB_RR_EN
    bus.ireq = 1'b0;
`else
    wait_ready(1'b1, lat);
    bus.ireq = 1'b0;
`endif

    repeat (6) @(posedge clk);
    #1;
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipelined core.
- Contains a request/grant FSM, registered memory-side outputs, read-data capture and one-cycle ready pulses.
- Fetch and memory stages stall while their request is high and their ready is low; hazard logic uses ready to release stalls.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte strobes are DW/8 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ireq  input  1  instruction fetch request; held until iready.
- iaddr  input  AW  fetch address.
- iflush  input  1  fetch stage flushed (branch/jump taken).
- iready  output  1  one-cycle pulse: irdata valid.
- irdata  output  DW  fetched instruction.
- dreq  input  1  data request; held until dready.
- dwe  input  1  1 = store, 0 = load.
- daddr  input  AW  data address.
- dwdata  input  DW  store data.
- dbe  input  DW/8  store byte enables.
- dready  output  1  one-cycle pulse: load data valid / store done.
- drdata  output  DW  load data.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_be  output  DW/8  memory byte enables; all ones on reads.
- mem_ack  input  1  memory completion, one cycle; read data valid in the same cycle.
- mem_rdata  input  DW  memory read data.

Behaviour:
- States: IDLE, IBUSY, DBUSY, IRESP, DRESP.
- Reset (async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; iready=dready=0; irdata=drdata=0; kill=0.
- IDLE:
  - If dreq, latch daddr/dwe/dwdata/dbe into the mem_* registers, set mem_req=1, go to DBUSY.
  - Else if ireq, latch iaddr, set mem_we=0 and mem_be all ones, set mem_req=1, go to IBUSY.
  - Arbitration is fixed: data wins, because the older instruction is in the memory stage.
- IBUSY/DBUSY:
  - mem_* outputs are held stable while mem_ack=0.
  - On a mem_ack edge: mem_req=0 and mem_we=0. On a read, mem_rdata is captured into irdata or drdata. Go to IRESP or DRESP.
- IRESP: iready=1 unless kill is set; clear kill; go to IDLE.
- DRESP: dready=1; go to IDLE.
- iready and dready are decoded from state, so each is high for exactly one cycle per transaction.
- Latency, request seen in cycle 0:
  - mem_req high in cycle 1.
  - mem_ack earliest in cycle 1.
  - ready in cycle ack+1.
  - IDLE in cycle ack+2; the next grant is evaluated in that cycle.
- A request present in the RESP cycle is ignored. The requester advances on the ready edge and presents its new request in IDLE.
- Flush:
  - iflush high in any IBUSY cycle, including the ack cycle, sets kill.
  - The memory read still completes (memory cannot abort), irdata is still updated, and the iready pulse is suppressed.
  - iflush in IRESP or IDLE has no effect on the current transaction.
- Requester drops req mid-transaction: the transaction completes and the ready pulse is still issued. This is harmless.
- mem_ack outside IBUSY/DBUSY is ignored.
- irdata and drdata hold their value until the next read capture for that port.
- Reset mid-transaction returns to IDLE immediately with mem_req=0. The memory must tolerate the abandoned request.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_RR_EN.
- Defined:
  - Add a last_grant flag, reset value = instruction.
  - On contention in IDLE (ireq and dreq both high), grant the requester that is not last_grant.
  - last_grant updates on every grant.
  - A single requester is always granted.
- Undefined: fixed data priority; no last_grant flop exists.

Test Plan:
- Fetch: ireq=1, iaddr=0x100, mem_ack one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, mem_be=0xF; iready pulses once; irdata=0x00500093.
- Store: dreq=1, dwe=1, daddr=0x2004, dwdata=0xDEADBEEF, dbe=0x3, ack after 3 wait cycles -> mem_* held stable for 4 cycles; mem_we=1, mem_be=0x3; single dready pulse; drdata unchanged.
- Contention: ireq and dreq both high from IDLE, daddr=0x40, iaddr=0x8 -> data served first (mem_addr=0x40); fetch granted in the IDLE cycle after DRESP (mem_addr=0x8).
- Flush: iflush pulsed during IBUSY, mem_rdata=0x1234 -> no iready pulse; irdata=0x1234; a following fetch returns a normal iready pulse.
- Reset: reset asserted in DBUSY -> mem_req=0 and all outputs at reset values asynchronously; post-reset ireq is served normally.
- RR (UNIFIED_MEM_ARB_RR_EN): ireq and dreq held continuously high with immediate ack -> grants alternate D,I,D,I; with the macro undefined -> D every time.
